// File: rtl/cbl_core.sv
// cbl_core: 5-stage in-order pipelined CPU (F/D/A/M/W) with forwarding, load-use stall and branch flush.
module cbl_ram #(
  parameter int W = 32,
  parameter int N = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);
  logic [W-1:0] data [N];
  always_ff @(posedge clk)
    if (we) data[waddr] <= wdata;
  assign q = data[raddr];
endmodule

module cbl_regfile #(
  parameter int W = 32,
  parameter int N = 10,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [W-1:0]  qa,
  output logic [W-1:0]  qb
);
  logic [W-1:0] data [N];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) data[i] <= '0;
    else if (we && 32'(waddr) < N) data[waddr] <= wdata;
  // write-through so D sees the value W is committing this cycle
  assign qa = (we && waddr == ra) ? wdata : (32'(ra) < N) ? data[ra] : '0;
  assign qb = (we && waddr == rb) ? wdata : (32'(rb) < N) ? data[rb] : '0;
endmodule

module cbl_core #(
  parameter int NUM_REG = 10,
  parameter int REG_WIDTH = 32,
  parameter int NUM_INSTR = 32,
  parameter int NUM_MEM = 5
) (
  input logic clk,
  input logic rst
);
  localparam int W = REG_WIDTH;
  localparam int RS = $clog2(NUM_REG);
  localparam int PW = $clog2(NUM_INSTR);
  localparam int MW = $clog2(NUM_MEM);
  localparam int OW = 4;
  localparam int IW = W - OW - 3 * RS;
  localparam logic [OW-1:0] ADD_OP = 4'd1, LW_OP = 4'd2, SW_OP = 4'd3, BEQ_OP = 4'd4;
  logic [PW-1:0] pc_F, pc_D, pc_A;
  logic [W-1:0] fetched, instruction_D, imm_D, imm_A;
  logic [OW-1:0] op_D;
  logic [RS-1:0] ra_D, rb_D, rd_D, rd_A, rd_M, rd_W;
  logic is_add_D, is_load_D, is_store_D, is_beq_D;
  logic is_add_A, is_load_A, is_store_A, is_beq_A;
  logic is_load_M, is_store_M, is_load_W, wr_A, wr_M, wr_W;
  logic [W-1:0] reg_a_D, reg_b_D, reg_a_A, reg_b_A, a, b, alu_data_A;
  logic [W-1:0] alu_M, b_M, mem_q, alu_W, mem_W, new_reg;
  logic forward_a_D, forward_b_D, select_forward_a_D, select_forward_b_D;
  logic forward_a_A, forward_b_A, select_forward_a_A, select_forward_b_A;
  logic match_aa, match_am, match_ba, match_bm, nop, taken, addr_ok;
  cbl_ram #(.W(W), .N(NUM_INSTR)) INSTRUCTIONS (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .raddr(pc_F), .q(fetched)
  );
  cbl_regfile #(.W(W), .N(NUM_REG)) REGISTERS (
    .clk(clk), .rst(rst), .we(wr_W), .waddr(rd_W), .wdata(new_reg),
    .ra(ra_D), .rb(rb_D), .qa(reg_a_D), .qb(reg_b_D)
  );
  cbl_ram #(.W(W), .N(NUM_MEM)) MEM (
    .clk(clk), .we(is_store_M && addr_ok), .waddr(alu_M[MW-1:0]), .wdata(b_M),
    .raddr(alu_M[MW-1:0]), .q(mem_q)
  );
  assign {op_D, ra_D, rb_D, rd_D} = instruction_D[W-1:IW];
  assign imm_D = {{(W - IW){instruction_D[IW-1]}}, instruction_D[IW-1:0]};
  assign is_add_D = op_D == ADD_OP;
  assign is_load_D = op_D == LW_OP;
  assign is_store_D = op_D == SW_OP;
  assign is_beq_D = op_D == BEQ_OP;
  assign wr_A = is_add_A | is_load_A;
  assign match_aa = wr_A && rd_A == ra_D;
  assign match_am = wr_M && rd_M == ra_D;
  assign match_ba = wr_A && rd_A == rb_D;
  assign match_bm = wr_M && rd_M == rb_D;
  assign forward_a_D = match_aa | match_am;
  assign forward_b_D = match_ba | match_bm;
  assign select_forward_a_D = !match_aa;
  assign select_forward_b_D = !match_ba;
  assign nop = is_load_A && ((match_aa && (is_add_D | is_load_D | is_store_D | is_beq_D)) ||
                             (match_ba && (is_add_D | is_store_D | is_beq_D)));
  assign new_reg = is_load_W ? mem_W : alu_W;
  assign a = forward_a_A ? (select_forward_a_A ? new_reg : alu_M) : reg_a_A;
  assign b = forward_b_A ? (select_forward_b_A ? new_reg : alu_M) : reg_b_A;
  assign alu_data_A = is_add_A ? a + b : a + imm_A;
  assign taken = is_beq_A && a == b;
  assign addr_ok = alu_M < NUM_MEM;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_F <= '0;
      pc_D <= '0;
      instruction_D <= '0;
      pc_A <= '0;
      rd_A <= '0;
      imm_A <= '0;
      reg_a_A <= '0;
      reg_b_A <= '0;
      {forward_a_A, forward_b_A, select_forward_a_A, select_forward_b_A} <= '0;
      {is_add_A, is_load_A, is_store_A, is_beq_A} <= '0;
      alu_M <= '0;
      b_M <= '0;
      rd_M <= '0;
      {wr_M, is_load_M, is_store_M} <= '0;
      alu_W <= '0;
      mem_W <= '0;
      rd_W <= '0;
      {wr_W, is_load_W} <= '0;
    end else begin
      if (taken) begin
        pc_F <= pc_A + PW'(imm_A << 2);
        instruction_D <= '0;
      end else if (!nop) begin
        pc_F <= pc_F + PW'(1);
        pc_D <= pc_F;
        instruction_D <= fetched;
      end
      pc_A <= pc_D;
      rd_A <= rd_D;
      imm_A <= imm_D;
      reg_a_A <= reg_a_D;
      reg_b_A <= reg_b_D;
      {forward_a_A, forward_b_A} <= {forward_a_D, forward_b_D};
      {select_forward_a_A, select_forward_b_A} <= {select_forward_a_D, select_forward_b_D};
      {is_add_A, is_load_A, is_store_A, is_beq_A} <=
        (taken || nop) ? 4'b0 : {is_add_D, is_load_D, is_store_D, is_beq_D};
      alu_M <= alu_data_A;
      b_M <= b;
      rd_M <= rd_A;
      {wr_M, is_load_M, is_store_M} <= {wr_A, is_load_A, is_store_A};
      alu_W <= alu_M;
      mem_W <= addr_ok ? mem_q : '0;
      rd_W <= rd_M;
      {wr_W, is_load_W} <= {wr_M, is_load_M};
    end
endmodule

// File: tb/tb_cbl_core.sv
// tb_cbl_core: scoreboard bench for cbl_core; expected register writes are queued per program and checked at W.
module tb_cbl_core;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  cbl_core dut (.clk(clk), .rst(rst));
  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, LW = 4'd2, SW = 4'd3, BEQ = 4'd4;
  typedef struct {
    int rd;
    logic [31:0] val;
  } wr_t;
  wr_t exp_q[$];
  wr_t e_mon;
  int vectors = 0, miscompares = 0, nop_cnt = 0;

  function automatic logic [31:0] enc(logic [3:0] op, int ra, int rb, int rd, int imm);
    return {op, 4'(ra), 4'(rb), 4'(rd), 16'(imm)};
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (dut.nop) nop_cnt++;
      if (dut.wr_W) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write r%0d=%0d required no write", dut.rd_W, dut.new_reg);
        end else begin
          e_mon = exp_q.pop_front();
          if (dut.rd_W !== 4'(e_mon.rd) || dut.new_reg !== e_mon.val) begin
            miscompares++;
            $display("FAIL wb_write got r%0d=%0d required r%0d=%0d", dut.rd_W, dut.new_reg, e_mon.rd, e_mon.val);
          end
        end
      end
    end

  task automatic clear(input logic [31:0] m0, m1, m2, m3, m4);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.INSTRUCTIONS.data[i] = '0;
    dut.MEM.data[0] = m0;
    dut.MEM.data[1] = m1;
    dut.MEM.data[2] = m2;
    dut.MEM.data[3] = m3;
    dut.MEM.data[4] = m4;
    exp_q.delete();
  endtask

  task automatic push(input int rd, input logic [31:0] v);
    wr_t w;
    w.rd = rd;
    w.val = v;
    exp_q.push_back(w);
  endtask

  task automatic release_rst;
    @(negedge clk);
    nop_cnt = 0;
    #1 rst = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout got %0d pending writes required 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic load_chain_prog;
    dut.INSTRUCTIONS.data[0] = enc(LW, 0, 0, 4, 0);
    dut.INSTRUCTIONS.data[1] = enc(LW, 0, 0, 0, 0);
    dut.INSTRUCTIONS.data[2] = enc(LW, 0, 0, 1, 0);
    dut.INSTRUCTIONS.data[3] = enc(ADD, 1, 0, 2, 0);
    dut.INSTRUCTIONS.data[4] = enc(SW, 1, 2, 0, 0);
    dut.INSTRUCTIONS.data[5] = enc(BEQ, 2, 2, 0, 1);
    for (int i = 6; i < 9; i++) dut.INSTRUCTIONS.data[i] = enc(ADD, 2, 2, 5, 0);
    dut.INSTRUCTIONS.data[9] = enc(ADD, 1, 0, 3, 0);
    push(4, 1); push(0, 1); push(1, 2); push(2, 3); push(3, 3);
  endtask

  task automatic check_load_chain(input string name);
    logic [31:0] er [5] = '{1, 2, 3, 3, 1};
    logic [31:0] em [3] = '{1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut.REGISTERS.data[i] !== er[i]) begin
        miscompares++;
        $display("FAIL %s_r%0d got %0d required %0d", name, i, dut.REGISTERS.data[i], er[i]);
      end
    end
    vectors++;
    if (dut.REGISTERS.data[5] !== 32'd0) begin
      miscompares++;
      $display("FAIL %s_r5 got %0d required 0", name, dut.REGISTERS.data[5]);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut.MEM.data[i] !== em[i]) begin
        miscompares++;
        $display("FAIL %s_mem%0d got %0d required %0d", name, i, dut.MEM.data[i], em[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if (dut.pc_F !== 5'd0 || dut.nop !== 1'b0 || dut.is_load_A !== 1'b0 || dut.forward_a_A !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got pc=%0d nop=%b ldA=%b fwdA=%b required 0 0 0 0",
               dut.pc_F, dut.nop, dut.is_load_A, dut.forward_a_A);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (dut.REGISTERS.data[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_r%0d got %0d required 0", i, dut.REGISTERS.data[i]);
      end
    end
  endtask

  task automatic test_load_chain;
    clear(1, 2, 0, 0, 0);
    load_chain_prog();
    release_rst();
    drain("load_chain");
    check_load_chain("load_chain");
    vectors++;
    if (nop_cnt !== 2) begin
      miscompares++;
      $display("FAIL load_chain_nops got %0d required 2", nop_cnt);
    end
  endtask

  task automatic test_load_use;
    clear(0, 0, 0, 10, 0);
    dut.INSTRUCTIONS.data[0] = enc(LW, 0, 0, 1, 3);
    dut.INSTRUCTIONS.data[1] = enc(ADD, 1, 1, 2, 0);
    push(1, 10); push(2, 20);
    release_rst();
    drain("load_use");
    vectors++;
    if (nop_cnt !== 1) begin
      miscompares++;
      $display("FAIL load_use_nops got %0d required 1", nop_cnt);
    end
    vectors++;
    if (dut.REGISTERS.data[2] !== 32'd20) begin
      miscompares++;
      $display("FAIL load_use_r2 got %0d required 20", dut.REGISTERS.data[2]);
    end
  endtask

  task automatic test_forward;
    clear(5, 0, 100, 0, 0);
    dut.INSTRUCTIONS.data[0] = enc(LW, 0, 0, 1, 0);
    dut.INSTRUCTIONS.data[3] = enc(ADD, 1, 1, 2, 0);
    dut.INSTRUCTIONS.data[4] = enc(ADD, 2, 1, 3, 0);
    dut.INSTRUCTIONS.data[5] = enc(ADD, 2, 3, 4, 0);
    dut.INSTRUCTIONS.data[6] = enc(ADD, 4, 2, 5, 0);
    dut.INSTRUCTIONS.data[7] = enc(ADD, 5, 5, 5, 0);
    dut.INSTRUCTIONS.data[8] = enc(ADD, 5, 4, 6, 0);
    dut.INSTRUCTIONS.data[9] = enc(LW, 0, 0, 7, 2);
    dut.INSTRUCTIONS.data[11] = enc(ADD, 7, 6, 8, 0);
    dut.INSTRUCTIONS.data[12] = enc(ADD, 8, 1, 0, 0);
    push(1, 5); push(2, 10); push(3, 15); push(4, 25); push(5, 35);
    push(5, 70); push(6, 95); push(7, 100); push(8, 195); push(0, 200);
    release_rst();
    drain("forward");
    vectors++;
    if (nop_cnt !== 0) begin
      miscompares++;
      $display("FAIL forward_nops got %0d required 0", nop_cnt);
    end
    vectors++;
    if (dut.REGISTERS.data[0] !== 32'd200 || dut.REGISTERS.data[8] !== 32'd195) begin
      miscompares++;
      $display("FAIL forward_final got r0=%0d r8=%0d required 200 195", dut.REGISTERS.data[0], dut.REGISTERS.data[8]);
    end
  endtask

  task automatic test_branch;
    clear(7, 7, 0, 0, 0);
    dut.INSTRUCTIONS.data[0] = enc(LW, 0, 0, 1, 0);
    dut.INSTRUCTIONS.data[1] = enc(LW, 0, 0, 2, 1);
    dut.INSTRUCTIONS.data[2] = enc(BEQ, 1, 2, 0, 1);
    for (int i = 3; i < 6; i++) dut.INSTRUCTIONS.data[i] = enc(ADD, 1, 1, 3, 0);
    dut.INSTRUCTIONS.data[6] = enc(BEQ, 1, 0, 0, 1);
    dut.INSTRUCTIONS.data[7] = enc(ADD, 1, 2, 4, 0);
    dut.INSTRUCTIONS.data[8] = enc(ADD, 4, 1, 5, 0);
    push(1, 7); push(2, 7); push(4, 14); push(5, 21);
    release_rst();
    drain("branch");
    vectors++;
    if (dut.REGISTERS.data[3] !== 32'd0 || dut.REGISTERS.data[5] !== 32'd21) begin
      miscompares++;
      $display("FAIL branch_final got r3=%0d r5=%0d required 0 21", dut.REGISTERS.data[3], dut.REGISTERS.data[5]);
    end
    vectors++;
    if (nop_cnt !== 1) begin
      miscompares++;
      $display("FAIL branch_nops got %0d required 1", nop_cnt);
    end
  endtask

  task automatic test_bounds;
    logic [31:0] em [5] = '{11, 12, 13, 14, 9};
    clear(11, 12, 13, 14, 9);
    dut.INSTRUCTIONS.data[0] = enc(LW, 0, 0, 1, 4);
    dut.INSTRUCTIONS.data[1] = enc(LW, 0, 0, 1, 7);
    dut.INSTRUCTIONS.data[2] = enc(LW, 0, 0, 2, 4);
    dut.INSTRUCTIONS.data[3] = enc(LW, 0, 0, 3, 8);
    dut.INSTRUCTIONS.data[5] = enc(SW, 0, 2, 0, 7);
    dut.INSTRUCTIONS.data[6] = enc(SW, 0, 2, 0, 8);
    dut.INSTRUCTIONS.data[7] = enc(SW, 0, 2, 0, 5);
    push(1, 9); push(1, 0); push(2, 9); push(3, 0);
    release_rst();
    drain("bounds");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut.MEM.data[i] !== em[i]) begin
        miscompares++;
        $display("FAIL bounds_mem%0d got %0d required %0d", i, dut.MEM.data[i], em[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    clear(1, 2, 0, 0, 0);
    load_chain_prog();
    release_rst();
    for (int i = 0; i < 100 && exp_q.size() > 3; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL reset_mid_progress got %0d pending required 3", exp_q.size());
    end
    @(posedge clk);
    #2 rst = 1;
    #1 rst = 0;
    exp_q.delete();
    push(4, 1); push(0, 1); push(1, 2); push(2, 3); push(3, 3);
    #1;
    vectors++;
    if (dut.pc_F !== 5'd0 || dut.is_load_A !== 1'b0 || dut.instruction_D !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_state got pc=%0d ldA=%b instD=%h required 0 0 0", dut.pc_F, dut.is_load_A, dut.instruction_D);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (dut.REGISTERS.data[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_mid_r%0d got %0d required 0", i, dut.REGISTERS.data[i]);
      end
    end
    drain("reset_mid");
    check_load_chain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_load_chain();
    test_load_use();
    test_forward();
    test_branch();
    test_bounds();
    test_reset_mid();
    rst = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
